// File: rtl/st7735_pkg.sv
// Shared opcodes and decoder state encoding for the ST7735 SPI receiver.
package st7735_pkg;

  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_RASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CASET = 2'd1,
    ST_RASET = 2'd2,
    ST_RAMWR = 2'd3
  } dec_state_e;

endpackage

// File: rtl/spi_byte_rx.sv
// Mode-0 SPI deserializer: synchronizes the raw pins into clk_i and emits {dc, byte} per 8 sclk edges.
module spi_byte_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       cs_i,
  input  logic       dc_i,
  input  logic       sclk_i,
  input  logic       mosi_i,
  output logic [8:0] byte_data_o,
  output logic       byte_valid_o,
  output logic       frame_err_o
);

  logic [SYNC_STAGES-1:0] cs_sync_q, dc_sync_q, sclk_sync_q, mosi_sync_q;
  logic       sclk_prev_q;
  logic [2:0] bit_cnt_q;
  logic [6:0] shift_q;
  logic [8:0] data_q;
  logic       valid_q, ferr_q;
  logic       cs_s, dc_s, sclk_s, mosi_s, sclk_rise;

  // cs resets high and sclk low so reset release never looks like an edge
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cs_sync_q   <= '1;
      dc_sync_q   <= '0;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
    end else begin
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_i};
      dc_sync_q   <= {dc_sync_q[SYNC_STAGES-2:0], dc_i};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
    end
  end

  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign dc_s      = dc_sync_q[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q & ~cs_s;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sclk_prev_q <= 1'b0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      sclk_prev_q <= sclk_s;
      valid_q     <= 1'b0;
      ferr_q      <= 1'b0;
      if (cs_s) begin
        if (bit_cnt_q != 3'd0) ferr_q <= 1'b1;
        bit_cnt_q <= '0;
      end else if (sclk_rise) begin
        shift_q   <= {shift_q[5:0], mosi_s};
        bit_cnt_q <= bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          data_q  <= {dc_s, shift_q, mosi_s};
          valid_q <= 1'b1;
        end
      end
    end
  end

  assign byte_data_o  = data_q;
  assign byte_valid_o = valid_q;
  assign frame_err_o  = ferr_q;

endmodule

// File: rtl/st7735_spi_rx.sv
// ST7735 command decoder: tracks the CASET/RASET window and turns RAMWR byte pairs into pixel strobes.
module st7735_spi_rx
  import st7735_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int X_MAX       = 127,
  parameter int Y_MAX       = 159
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        cs,
  input  logic        dc,
  input  logic        sclk,
  input  logic        mosi,
  output logic [8:0]  rx_data,
  output logic        rx_valid,
  output logic        frame_err,
  output logic        win_err,
  output logic        pix_valid,
  output logic [7:0]  pix_x,
  output logic [7:0]  pix_y,
  output logic [15:0] pix_color
);

  dec_state_e state_q, state_d;
  logic [1:0]  cnt_q;
  logic        hi_err_q, phase_q;
  logic [7:0]  start_lo_q, hi_q;
  logic [7:0]  xs_q, xe_q, ys_q, ye_q, x_q, y_q;
  logic        pix_valid_q, win_err_q;
  logic [7:0]  pix_x_q, pix_y_q;
  logic [15:0] pix_color_q;
  logic        cmd_byte, data_byte, enter_ramwr, pix_fire;
  logic [7:0]  b;

  spi_byte_rx #(.SYNC_STAGES(SYNC_STAGES)) u_byte_rx (
    .clk_i        (sys_clk),
    .rst_n_i      (sys_rst_n),
    .cs_i         (cs),
    .dc_i         (dc),
    .sclk_i       (sclk),
    .mosi_i       (mosi),
    .byte_data_o  (rx_data),
    .byte_valid_o (rx_valid),
    .frame_err_o  (frame_err)
  );

  assign b = rx_data[7:0];

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (rx_valid) begin
      if (!rx_data[8]) begin
        case (b)
          CMD_CASET: state_d = ST_CASET;
          CMD_RASET: state_d = ST_RASET;
          CMD_RAMWR: state_d = ST_RAMWR;
          default:   state_d = ST_IDLE;
        endcase
      end else if ((state_q == ST_CASET || state_q == ST_RASET) && cnt_q == 2'd3) begin
        state_d = ST_IDLE;
      end
    end
  end

  always_comb begin
    cmd_byte    = rx_valid & ~rx_data[8];
    data_byte   = rx_valid & rx_data[8];
    enter_ramwr = cmd_byte & (b == CMD_RAMWR);
    pix_fire    = data_byte & (state_q == ST_RAMWR) & phase_q;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q       <= '0;
      hi_err_q    <= 1'b0;
      phase_q     <= 1'b0;
      start_lo_q  <= '0;
      hi_q        <= '0;
      xs_q        <= '0;
      xe_q        <= 8'(X_MAX);
      ys_q        <= '0;
      ye_q        <= 8'(Y_MAX);
      x_q         <= '0;
      y_q         <= '0;
      pix_valid_q <= 1'b0;
      win_err_q   <= 1'b0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
      pix_color_q <= '0;
    end else begin
      pix_valid_q <= 1'b0;
      win_err_q   <= 1'b0;
      if (cmd_byte) begin
        cnt_q    <= '0;
        phase_q  <= 1'b0;
        hi_err_q <= 1'b0;
        if (enter_ramwr) begin
          x_q <= xs_q;
          y_q <= ys_q;
        end
      end else if (data_byte) begin
        case (state_q)
          ST_CASET, ST_RASET: begin
            cnt_q <= cnt_q + 2'd1;
            case (cnt_q)
              2'd0: hi_err_q   <= |b;
              2'd1: start_lo_q <= b;
              2'd2: hi_err_q   <= hi_err_q | (|b);
              default: begin
                win_err_q <= hi_err_q;
                if (state_q == ST_CASET) begin
                  xs_q <= start_lo_q;
                  xe_q <= b;
                end else begin
                  ys_q <= start_lo_q;
                  ye_q <= b;
                end
              end
            endcase
          end
          ST_RAMWR: begin
            if (!pix_fire) begin
              hi_q    <= b;
              phase_q <= 1'b1;
            end else begin
              phase_q     <= 1'b0;
              pix_valid_q <= 1'b1;
              pix_x_q     <= x_q;
              pix_y_q     <= y_q;
              pix_color_q <= {hi_q, b};
              // column wraps into the next row, row wraps back to the window top
              if (x_q >= xe_q) begin
                x_q <= xs_q;
                y_q <= (y_q >= ye_q) ? ys_q : y_q + 8'd1;
              end else begin
                x_q <= x_q + 8'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign pix_valid = pix_valid_q;
  assign win_err   = win_err_q;
  assign pix_x     = pix_x_q;
  assign pix_y     = pix_y_q;
  assign pix_color = pix_color_q;

endmodule

// File: tb/tb_st7735_spi_rx.sv
// Directed bench for st7735_spi_rx: byte/command table plus frame-error and reset sequences.
module tb_st7735_spi_rx;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        cs = 1'b1, dc = 1'b0, sclk = 1'b0, mosi = 1'b0;
  logic [8:0]  rx_data;
  logic        rx_valid, frame_err, win_err, pix_valid;
  logic [7:0]  pix_x, pix_y;
  logic [15:0] pix_color;

  int n_checks = 0, n_err = 0;
  int n_rx = 0, n_fe = 0, n_we = 0, n_pix = 0;

  st7735_spi_rx dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .cs        (cs),
    .dc        (dc),
    .sclk      (sclk),
    .mosi      (mosi),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .win_err   (win_err),
    .pix_valid (pix_valid),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pix_color (pix_color)
  );

  always #5 sys_clk = ~sys_clk;

  always @(negedge sys_clk) begin
    if (rx_valid)  n_rx++;
    if (frame_err) n_fe++;
    if (win_err)   n_we++;
    if (pix_valid) n_pix++;
  end

  typedef struct {
    logic        dc;
    logic [7:0]  b;
    logic        pix;
    logic [7:0]  px;
    logic [7:0]  py;
    logic [15:0] col;
    logic        werr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic d, input logic [7:0] v, input logic p = 1'b0,
                     input logic [7:0] x = 8'h0, input logic [7:0] y = 8'h0,
                     input logic [15:0] c = 16'h0, input logic w = 1'b0);
    vec_t e;
    e.dc = d; e.b = v; e.pix = p; e.px = x; e.py = y; e.col = c; e.werr = w;
    vecs.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_bits(input logic d, input logic [7:0] v, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      @(negedge sys_clk);
      mosi = v[i]; dc = d; sclk = 1'b0;
      repeat (3) @(negedge sys_clk);
      sclk = 1'b1;
      repeat (4) @(negedge sys_clk);
    end
    @(negedge sys_clk);
    sclk = 1'b0;
    repeat (4) @(negedge sys_clk);
  endtask

  task automatic send_byte(input logic d, input logic [7:0] v);
    send_bits(d, v, 8);
    repeat (4) @(negedge sys_clk);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, " rx_data"},   32'(rx_data),   32'h0);
    check({tag, " strobes"},   32'({rx_valid, frame_err, win_err, pix_valid}), 32'h0);
    check({tag, " pix_xy"},    32'({pix_x, pix_y}), 32'h0);
    check({tag, " pix_color"}, 32'(pix_color), 32'h0);
  endtask

  initial begin
    int rx0, fe0, we0, pix0;

    // byte stream: 2C/F8 00, window 16..17 x 32..33 walk, bad CASET, orphaned hi byte, partial CASET
    add(0, 8'h2C);
    add(1, 8'hF8);
    add(1, 8'h00, 1, 8'd0, 8'd0, 16'hF800);
    add(0, 8'h2A); add(1, 8'h00); add(1, 8'h10); add(1, 8'h00); add(1, 8'h11);
    add(0, 8'h2B); add(1, 8'h00); add(1, 8'h20); add(1, 8'h00); add(1, 8'h21);
    add(0, 8'h2C);
    add(1, 8'h00); add(1, 8'h01, 1, 8'd16, 8'd32, 16'h0001);
    add(1, 8'h00); add(1, 8'h02, 1, 8'd17, 8'd32, 16'h0002);
    add(1, 8'h00); add(1, 8'h03, 1, 8'd16, 8'd33, 16'h0003);
    add(1, 8'h00); add(1, 8'h04, 1, 8'd17, 8'd33, 16'h0004);
    add(1, 8'h00); add(1, 8'h05, 1, 8'd16, 8'd32, 16'h0005);
    add(0, 8'h2A); add(1, 8'h01); add(1, 8'h00); add(1, 8'h00);
    add(1, 8'h7F, 0, 8'h0, 8'h0, 16'h0, 1);
    add(0, 8'h2C); add(1, 8'h12); add(0, 8'h00); add(1, 8'h55);
    add(0, 8'h2C); add(1, 8'hAB); add(1, 8'hCD, 1, 8'd0, 8'd32, 16'hABCD);
    add(0, 8'h2A); add(1, 8'h00); add(1, 8'h05);
    add(0, 8'h2C); add(1, 8'h11); add(1, 8'h22, 1, 8'd0, 8'd32, 16'h1122);

    repeat (3) @(negedge sys_clk);
    check_outputs_zero("reset");
    sys_rst_n = 1'b1;
    repeat (4) @(negedge sys_clk);
    cs = 1'b0;
    repeat (6) @(negedge sys_clk);

    // cs raised after 5 bits
    rx0 = n_rx; fe0 = n_fe;
    send_bits(1, 8'hFF, 5);
    cs = 1'b1;
    repeat (10) @(negedge sys_clk);
    check("abort frame_err", 32'(n_fe - fe0), 32'd1);
    check("abort no rx",     32'(n_rx - rx0), 32'd0);
    cs = 1'b0;
    repeat (6) @(negedge sys_clk);
    rx0 = n_rx; fe0 = n_fe; pix0 = n_pix;
    send_byte(1, 8'hA5);
    check("recover rx_data", 32'(rx_data), 32'h1A5);
    check("recover rx cnt",  32'(n_rx - rx0), 32'd1);
    check("recover no fe",   32'(n_fe - fe0), 32'd0);
    check("idle no pix",     32'(n_pix - pix0), 32'd0);

    foreach (vecs[i]) begin
      rx0 = n_rx; we0 = n_we; pix0 = n_pix;
      send_byte(vecs[i].dc, vecs[i].b);
      check($sformatf("v%0d rx_data", i), 32'(rx_data), 32'({vecs[i].dc, vecs[i].b}));
      check($sformatf("v%0d rx cnt", i),  32'(n_rx - rx0), 32'd1);
      check($sformatf("v%0d pix cnt", i), 32'(n_pix - pix0), 32'(vecs[i].pix));
      check($sformatf("v%0d win cnt", i), 32'(n_we - we0), 32'(vecs[i].werr));
      if (vecs[i].pix) begin
        check($sformatf("v%0d pix_x", i),     32'(pix_x), 32'(vecs[i].px));
        check($sformatf("v%0d pix_y", i),     32'(pix_y), 32'(vecs[i].py));
        check($sformatf("v%0d pix_color", i), 32'(pix_color), 32'(vecs[i].col));
      end
    end

    // reset pulsed mid-RAMWR and mid-byte
    send_byte(0, 8'h2C);
    send_byte(1, 8'h11);
    rx0 = n_rx; fe0 = n_fe; we0 = n_we; pix0 = n_pix;
    send_bits(1, 8'h22, 3);
    sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    check_outputs_zero("midrst");
    sys_rst_n = 1'b1;
    repeat (10) @(negedge sys_clk);
    check("midrst no strobe", 32'((n_rx - rx0) + (n_fe - fe0) + (n_we - we0) + (n_pix - pix0)), 32'd0);
    pix0 = n_pix;
    send_byte(1, 8'h33);
    send_byte(1, 8'h44);
    check("post-rst idle no pix", 32'(n_pix - pix0), 32'd0);
    send_byte(0, 8'h2C);
    send_byte(1, 8'h44);
    send_byte(1, 8'h55);
    check("post-rst pix cnt",   32'(n_pix - pix0), 32'd1);
    check("post-rst pix_xy",    32'({pix_x, pix_y}), 32'h0000);
    check("post-rst pix_color", 32'(pix_color), 32'h4455);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/st7735_spi_rx.md
ST7735_SPI_RX -- requirements
Module: st7735_spi_rx

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer depth on cs/dc/sclk/mosi, legal range 2..3.
REQ-002 Parameter X_MAX, default 127: reset column end address.
REQ-003 Parameter Y_MAX, default 159: reset row end address.
REQ-004 Port sys_clk, input, 1: sole clock; runs at least 4x the sclk rate.
REQ-005 Port sys_rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-006 Port cs, input, 1: SPI chip select, active-low, asynchronous to sys_clk.
REQ-007 Port dc, input, 1: 0 = command byte, 1 = data byte.
REQ-008 Port sclk, input, 1: SPI clock, mode 0, sampled on its rising edge.
REQ-009 Port mosi, input, 1: serial data, MSB first.
REQ-010 Port rx_data, output, 9: {dc, byte} of the last completed byte.
REQ-011 Port rx_valid, output, 1: one-cycle strobe; rx_data is new.
REQ-012 Port frame_err, output, 1: one-cycle strobe; cs rose mid-byte.
REQ-013 Port win_err, output, 1: one-cycle strobe; a CASET/RASET high byte was nonzero.
REQ-014 Port pix_valid, output, 1: one-cycle strobe; a pixel was written.
REQ-015 Port pix_x, output, 8: column of the written pixel.
REQ-016 Port pix_y, output, 8: row of the written pixel.
REQ-017 Port pix_color, output, 16: RGB565 value of the written pixel.

Function
REQ-018 cs, dc, sclk and mosi each pass through a SYNC_STAGES flip-flop synchronizer; all logic uses only the synchronized copies.
REQ-019 An sclk rising edge is a synchronized 0->1 transition detected while synchronized cs is 0; mosi is shifted in MSB first on that edge.
REQ-020 A 3-bit bit counter increments on each edge; on the 8th edge it wraps to 0, dc is captured, and rx_data and rx_valid update in the next sys_clk cycle.
REQ-021 If cs goes high with a bit count of 1..7, the partial byte is discarded, the counter clears, and frame_err pulses once; no rx_valid is generated.
REQ-022 If cs goes high with a bit count of 0, no error is flagged, and decoder state persists across cs toggles.
REQ-023 The decoder FSM has states IDLE, CASET, RASET and RAMWR and consumes exactly one byte per rx_valid.
REQ-024 Any byte with dc = 0 aborts the current state; 0x2A enters CASET, 0x2B enters RASET, 0x2C enters RAMWR, and any other command enters IDLE.
REQ-025 In IDLE, data bytes are ignored.
REQ-026 CASET collects 4 data bytes: XS_hi, XS_lo, XE_hi, XE_lo.
REQ-027 On the 4th CASET byte, xs and xe load from the low bytes and the FSM returns to IDLE.
REQ-028 If fewer than 4 CASET bytes arrive, the window is unchanged.
REQ-029 RASET behaves identically to CASET, loading ys and ye.
REQ-030 If any high byte in CASET/RASET is nonzero, win_err pulses on the final byte; the low bytes are still loaded.
REQ-031 Entering RAMWR sets the cursor to (xs, ys) and the byte phase to high.
REQ-032 Each RAMWR data-byte pair {hi, lo} produces pix_valid in the cycle after the lo byte's rx_valid, with pix_x/pix_y equal to the cursor before advance and pix_color = {hi, lo}.
REQ-033 After each pixel the column advances: if x >= xe then x = xs and y advances, else x increments.
REQ-034 The row advances the same way: if y >= ye then y = ys, else y increments.
REQ-035 A command byte arriving after an odd number of RAMWR data bytes discards the pending hi byte.
REQ-036 pix_x, pix_y, pix_color and rx_data hold their values between strobes.

Reset
REQ-037 While sys_rst_n = 0, all outputs are 0: rx_data = 9'h000, rx_valid, frame_err, win_err and pix_valid = 0, pix_x = pix_y = 0, pix_color = 16'h0000.
REQ-038 While sys_rst_n = 0, the FSM is in IDLE, the bit counter is 0, xs = ys = 0, xe = X_MAX and ye = Y_MAX.
REQ-039 The synchronizers reset to cs = 1 and sclk = 0, so no false edge follows reset release.
REQ-040 Reset asserted mid-byte or mid-RAMWR discards all partial state; no strobe is emitted.

Structure
REQ-041 Command opcodes 0x2A, 0x2B and 0x2C and the FSM state encodings live in a shared package, st7735_pkg.
REQ-042 The bit-level deserializer (REQ-018 to REQ-022) is a sub-module, spi_byte_rx; command decoding and cursor logic live in the top module.

Verification
REQ-043 Scenario: cs low, send 0x2C with dc = 0 -> rx_data = 9'h02C with one rx_valid.
REQ-044 Scenario: send 0xF8, 0x00 with dc = 1 -> pix_valid with pix_x = 0, pix_y = 0, pix_color = 16'hF800.
REQ-045 Scenario: CASET 00 10 00 11, RASET 00 20 00 21, RAMWR, 5 pixels -> pixels at (16,32), (17,32), (16,33), (17,33), (16,32).
REQ-046 Scenario: cs raised after 5 bits -> one frame_err, no rx_valid; the next full byte 0xA5 is received correctly.
REQ-047 Scenario: CASET 01 00 00 7F -> win_err pulse, xs = 0x00, xe = 0x7F.
REQ-048 Scenario: RAMWR, one data byte, then command 0x00, then RAMWR and 2 bytes -> exactly one pix_valid, at (xs, ys).
REQ-049 Scenario: sys_rst_n pulsed low mid-RAMWR -> all outputs 0; the next pixel requires a new RAMWR.
